uart_tx_top: RTL and testbench

Transmit half of the UART: a small write-side FIFO buffers bytes from the host, and a serializer drains them onto the `tx` line. Each byte goes out as one frame: start bit, N_BIT data bits LSB first, optional parity bit, then stop bit(s). It shares the baud generator's `S_tick` (16× oversample enable) with the receive path. It is the counterpart of the receiver top, so the two can be looped back `tx`→`rx` for test.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 79 +++++++
 rtl/uart_tx_top.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_top.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, frame state encoding
// (common to the TX and RX paths) and the parity helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = 4;
  localparam int PAR_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity is the XOR of the data; odd parity is its complement.
  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [PAR_W-1:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through FIFO for the UART transmitter. The head entry is
// always presented on rd_data; full and empty are registered flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int N_BIT   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [N_BIT-1:0] wr_data,
  input  logic             rd_en,
  output logic [N_BIT-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2**FIFO_AW;

  logic [N_BIT-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic               r_full;
  logic               r_empty;

  logic               w_push;
  logic               w_pop;
  logic [FIFO_AW-1:0] w_wptr_nxt;
  logic [FIFO_AW-1:0] w_rptr_nxt;

  // A push while full and a pop while empty are both dropped here, so the
  // storage is never overwritten and the read pointer never runs past data.
  assign w_push     = wr_en && !r_full;
  assign w_pop      = rd_en && !r_empty;
  assign w_wptr_nxt = r_wptr + FIFO_AW'(1);
  assign w_rptr_nxt = r_rptr + FIFO_AW'(1);

  // Storage array: written on accepted pushes, contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointer and flag update; simultaneous push and pop leaves the flags alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10: begin
          r_empty <= 1'b0;
          r_full  <= (w_wptr_nxt == r_rptr);
        end
        2'b01: begin
          r_full  <= 1'b0;
          r_empty <= (w_rptr_nxt == r_wptr);
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: write FIFO plus frame serializer driven by the shared
// 16x oversample enable S_tick.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | line high; pops the FIFO head as soon as one is present
//   ST_START  | start bit (low) for 16 S_ticks
//   ST_DATA   | N_BIT data bits, LSB first, 16 S_ticks each
//   ST_PARITY | parity bit for 16 S_ticks (only when PARITY_EN)
//   ST_STOP   | line high for SB_TICK S_ticks, then done pulse
//
// All outputs are flops. tx and tx_busy are loaded from the state the FSM is
// in, so they trail a state change by one clk: a pop at edge n shows tx low
// and tx_busy high at edge n+1. tx_busy is cleared directly on the edge that
// ends the stop period so it falls together with tx_done_tick.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int N_BIT      = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_tick,
  input  logic             tx_wr_en,
  input  logic [N_BIT-1:0] tx_wr_data,
  output logic             tx,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  // The tick counter is 4 bits for bit periods; it widens only when the stop
  // period is longer than one bit.
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : TICK_W;
  localparam int N_W = (N_BIT > 1) ? $clog2(N_BIT) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(N_BIT - 1);

  uart_state_e      r_state;
  logic [S_W-1:0]   r_s;
  logic [N_W-1:0]   r_n;
  logic [N_BIT-1:0] r_b;
  logic             r_par;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic [N_BIT-1:0] w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;

  // Only IDLE pops, and only when there is something to pop.
  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  uart_tx_fifo #(
    .N_BIT   (N_BIT),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_wr_en),
    .wr_data (tx_wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (!w_empty) begin
            r_b     <= w_head;
            r_par   <= calc_parity(PAR_W'(w_head), (PARITY_ODD != 0));
            r_s     <= '0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          r_tx   <= 1'b0;
          r_busy <= 1'b1;
          if (S_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= ST_DATA;
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        ST_DATA: begin
          r_tx   <= r_b[0];
          r_busy <= 1'b1;
          if (S_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == N_LAST) begin
                r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                r_n <= r_n + N_W'(1);
              end
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        ST_PARITY: begin
          r_tx   <= r_par;
          r_busy <= 1'b1;
          if (S_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        ST_STOP: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b1;
          if (S_tick) begin
            if (r_s == S_STOP_LAST) begin
              r_s     <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_s <= r_s + S_W'(1);
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;
  assign tx_full      = w_full;
  assign tx_empty     = w_empty;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: three instances (default, no-parity/2-stop, odd
// parity). The line is sampled once per S_tick and decoded into frames by a
// bench-side receiver model, which is compared with the bytes pushed.
module tb_uart_tx_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic S_tick = 1'b0;

  logic       wr_en0 = 1'b0, wr_en1 = 1'b0, wr_en2 = 1'b0;
  logic [7:0] wr_data0 = '0, wr_data1 = '0, wr_data2 = '0;
  logic tx0, full0, empty0, busy0, done0;
  logic tx1, full1, empty1, busy1, done1;
  logic tx2, full2, empty2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_top dut0 (
    .clk(clk), .rst(rst), .S_tick(S_tick), .tx_wr_en(wr_en0), .tx_wr_data(wr_data0),
    .tx(tx0), .tx_full(full0), .tx_empty(empty0), .tx_busy(busy0), .tx_done_tick(done0)
  );

  uart_tx_top #(.PARITY_EN(0), .SB_TICK(32)) dut1 (
    .clk(clk), .rst(rst), .S_tick(S_tick), .tx_wr_en(wr_en1), .tx_wr_data(wr_data1),
    .tx(tx1), .tx_full(full1), .tx_empty(empty1), .tx_busy(busy1), .tx_done_tick(done1)
  );

  uart_tx_top #(.PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .S_tick(S_tick), .tx_wr_en(wr_en2), .tx_wr_data(wr_data2),
    .tx(tx2), .tx_full(full2), .tx_empty(empty2), .tx_busy(busy2), .tx_done_tick(done2)
  );

  // S_tick generator: one-clk pulse every tick_div clocks, changed on negedges
  logic tick_en = 1'b0;
  int   tick_div = 4;
  int   tick_cnt = 0;
  always @(negedge clk) begin
    if (tick_en) begin
      if (tick_cnt >= tick_div - 1) begin
        S_tick = 1'b1;
        tick_cnt = 0;
      end else begin
        S_tick = 1'b0;
        tick_cnt++;
      end
    end else begin
      S_tick = 1'b0;
      tick_cnt = 0;
    end
  end

  // Line capture: one sample per S_tick, taken half a clock after the edge
  // that consumed the tick; done pulses recorded as sample indices.
  logic tick_seen = 1'b0;
  logic cap_en = 1'b0;
  logic q0[$], q1[$], q2[$];
  int   d0[$], d1[$], d2[$];
  int   done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
  logic done_prev0 = 1'b0;
  int   done_wide = 0;

  always @(posedge clk) tick_seen = S_tick;

  always @(negedge clk) begin
    if (cap_en && tick_seen) begin
      q0.push_back(tx0);
      q1.push_back(tx1);
      q2.push_back(tx2);
    end
    if (done0) begin done_cnt0++; if (cap_en) d0.push_back(q0.size()); end
    if (done1) begin done_cnt1++; if (cap_en) d1.push_back(q1.size()); end
    if (done2) begin done_cnt2++; if (cap_en) d2.push_back(q2.size()); end
    if (done0 && done_prev0) done_wide++;
    done_prev0 = done0;
  end

  // Receiver model: frames are a low start bit, 8 data bits LSB first, an
  // optional parity bit, each 16 samples, then sb high samples.
  task automatic decode(input logic smp[$], input int pe, input int po, input int sb,
                        output logic [7:0] bytes[$], output logic pbits[$],
                        output int starts[$], output int ferr, output int perr);
    int i;
    int n;
    logic [7:0] d;
    logic v;
    bytes = {}; pbits = {}; starts = {};
    ferr = 0; perr = 0; i = 0; n = smp.size(); d = '0;
    while (i < n) begin
      if (smp[i] !== 1'b0) begin
        i++;
      end else begin
        starts.push_back(i);
        for (int k = 0; k < 16; k++) begin
          if (i >= n || smp[i] !== 1'b0) ferr++;
          i++;
        end
        for (int bt = 0; bt < 8; bt++) begin
          v = (i < n) ? smp[i] : 1'bx;
          d[bt] = v;
          for (int k = 0; k < 16; k++) begin
            if (i >= n || smp[i] !== v) ferr++;
            i++;
          end
        end
        if (pe != 0) begin
          v = (i < n) ? smp[i] : 1'bx;
          pbits.push_back(v);
          for (int k = 0; k < 16; k++) begin
            if (i >= n || smp[i] !== v) ferr++;
            i++;
          end
          if (v !== ((^d) ^ (po != 0))) perr++;
        end
        for (int k = 0; k < sb; k++) begin
          if (i >= n || smp[i] !== 1'b1) ferr++;
          i++;
        end
        bytes.push_back(d);
      end
    end
  endtask

  task automatic clear_capture();
    q0.delete(); q1.delete(); q2.delete();
    d0.delete(); d1.delete(); d2.delete();
    cap_en = 1'b1;
  endtask

  task automatic push(input int inst, input logic [7:0] d);
    @(negedge clk);
    case (inst)
      0: begin wr_en0 = 1'b1; wr_data0 = d; end
      1: begin wr_en1 = 1'b1; wr_data1 = d; end
      default: begin wr_en2 = 1'b1; wr_data2 = d; end
    endcase
    @(negedge clk);
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int target, input int budget, output bit ok);
    int cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cnt = (inst == 0) ? done_cnt0 : (inst == 1) ? done_cnt1 : done_cnt2;
      if (cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty0); end
    checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full0); end
  endtask

  // Push into an idle, empty FIFO with S_tick held low: pop one edge later,
  // line low and busy one edge after that.
  task automatic test_push_timing();
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    wr_en0 = 1'b1; wr_data0 = 8'hA5;
    @(posedge clk); #1;
    checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL timing_k_empty got %b exp 0", empty0); end
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL timing_k_tx got %b exp 1", tx0); end
    @(negedge clk); wr_en0 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({tx0, busy0} !== 2'b10) begin errors++; $display("FAIL timing_k1_tx_busy got %b exp 10", {tx0, busy0}); end
    @(posedge clk); #1;
    checks++; if ({tx0, busy0} !== 2'b01) begin errors++; $display("FAIL timing_k2_tx_busy got %b exp 01", {tx0, busy0}); end
  endtask

  // Continues the 0xA5 frame: queue two more bytes, reset during data bit 3.
  task automatic test_reset_mid();
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base;
    bit ok;
    push(0, 8'h5A);
    push(0, 8'hC3);
    clear_capture();
    tick_en = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (q0.size() >= 16 + 3 * 16 + 8) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_bit3 got timeout exp bit3"); end
    checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL rstmid_bit3_level got %b exp 0", tx0); end
    base = done_cnt0;
    #2 rst = 1'b0;
    #1;
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL rstmid_async_tx got %b exp 1", tx0); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({empty0, full0, busy0, tx0} !== 4'b1001) begin
      errors++; $display("FAIL rstmid_after got empty,full,busy,tx=%b exp 1001", {empty0, full0, busy0, tx0});
    end
    clear_capture();
    repeat (400) @(negedge clk);
    checks++; if (done_cnt0 !== base) begin errors++; $display("FAIL rstmid_no_done got %0d exp %0d", done_cnt0, base); end
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    checks++; if (bytes.size() !== 0) begin errors++; $display("FAIL rstmid_no_frames got %0d exp 0", bytes.size()); end
  endtask

  task automatic test_single_byte();
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base;
    bit ok;
    tick_div = 4;
    clear_capture();
    tick_en = 1'b1;
    base = done_cnt0;
    done_wide = 0;
    push(0, 8'h07);
    wait_done(0, base + 1, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got none exp 1"); end
    repeat (40) @(negedge clk);
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    checks++; if (bytes.size() !== 1 || bytes[0] !== 8'h07) begin
      errors++; $display("FAIL single_byte got n=%0d b=%h exp n=1 b=07", bytes.size(), (bytes.size() > 0) ? bytes[0] : 8'hxx);
    end
    checks++; if (pbits.size() !== 1 || pbits[0] !== 1'b1) begin errors++; $display("FAIL single_parity got n=%0d exp bit 1", pbits.size()); end
    checks++; if (ferr !== 0) begin errors++; $display("FAIL single_framing got %0d bad samples exp 0", ferr); end
    checks++; if (d0.size() !== 1 || starts.size() !== 1 || d0[0] - starts[0] !== 176) begin
      errors++; $display("FAIL single_length got %0d exp 176", (d0.size() > 0 && starts.size() > 0) ? d0[0] - starts[0] : -1);
    end
    checks++; if (done_cnt0 - base !== 1 || done_wide !== 0) begin
      errors++; $display("FAIL single_done_pulse got count %0d wide %0d exp 1 0", done_cnt0 - base, done_wide);
    end
    checks++; if ({empty0, busy0} !== 2'b10) begin errors++; $display("FAIL single_end_state got %b exp 10", {empty0, busy0}); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q[$];
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base;
    bit ok;
    exp_q = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    clear_capture();
    tick_en = 1'b1;
    base = done_cnt0;
    foreach (exp_q[i]) push(0, exp_q[i]);
    wait_done(0, base + 4, 4 * 176 * 4 + 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_done_timeout got %0d exp 4", done_cnt0 - base); end
    repeat (40) @(negedge clk);
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    checks++; if (bytes.size() !== 4) begin errors++; $display("FAIL loop_count got %0d exp 4", bytes.size()); end
    foreach (exp_q[i]) begin
      checks++; if (i >= bytes.size() || bytes[i] !== exp_q[i]) begin
        errors++; $display("FAIL loop_byte%0d got %h exp %h", i, (i < bytes.size()) ? bytes[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (perr !== 0 || ferr !== 0) begin errors++; $display("FAIL loop_errors got parity %0d frame %0d exp 0 0", perr, ferr); end
  endtask

  task automatic test_full();
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base;
    bit ok;
    tick_en = 1'b0;
    repeat (8) @(negedge clk);
    clear_capture();
    base = done_cnt0;
    for (int i = 0; i < 5; i++) begin
      wr_en0 = 1'b1;
      wr_data0 = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    wr_en0 = 1'b0;
    checks++; if ({full0, busy0} !== 2'b11) begin errors++; $display("FAIL full_flag got full,busy=%b exp 11", {full0, busy0}); end
    push(0, 8'h66);
    checks++; if ({full0, empty0} !== 2'b10) begin errors++; $display("FAIL full_after_drop got full,empty=%b exp 10", {full0, empty0}); end
    tick_en = 1'b1;
    wait_done(0, base + 5, 5 * 176 * 4 + 1000, ok);
    repeat (200) @(negedge clk);
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    checks++; if (!ok || bytes.size() !== 5) begin errors++; $display("FAIL full_count got %0d exp 5", bytes.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (i >= bytes.size() || bytes[i] !== 8'(8'h11 * (i + 1))) begin
        errors++; $display("FAIL full_byte%0d got %h exp %h", i, (i < bytes.size()) ? bytes[i] : 8'hxx, 8'(8'h11 * (i + 1)));
      end
    end
  endtask

  // Second byte pushed on the very edge that pops the only entry.
  task automatic test_simultaneous();
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base, glitch;
    bit ok;
    tick_en = 1'b0;
    repeat (8) @(negedge clk);
    clear_capture();
    base = done_cnt0;
    wr_en0 = 1'b1; wr_data0 = 8'h3C;
    @(negedge clk);
    wr_data0 = 8'hE1;
    @(negedge clk);
    wr_en0 = 1'b0;
    checks++; if ({empty0, full0} !== 2'b00) begin errors++; $display("FAIL simul_after_pop got empty,full=%b exp 00", {empty0, full0}); end
    tick_en = 1'b1;
    glitch = 0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done0) begin ok = 1'b1; break; end
      if (empty0 !== 1'b0) glitch++;
    end
    checks++; if (!ok || glitch !== 0) begin errors++; $display("FAIL simul_no_empty_glitch got %0d cycles empty exp 0", glitch); end
    wait_done(0, base + 2, 3000, ok);
    repeat (40) @(negedge clk);
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    checks++; if (!ok || bytes.size() !== 2 || bytes[0] !== 8'h3C || bytes[1] !== 8'hE1) begin
      errors++; $display("FAIL simul_order got n=%0d exp 3c then e1", bytes.size());
    end
  endtask

  task automatic test_config();
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, b1, b2, ones, last;
    logic [7:0] dbyte;
    logic exp_par;
    bit ok1, ok2;
    tick_div = 4;
    clear_capture();
    tick_en = 1'b1;
    b1 = done_cnt1; b2 = done_cnt2;
    push(1, 8'h80);
    push(2, 8'h07);
    wait_done(1, b1 + 1, 3000, ok1);
    wait_done(2, b2 + 1, 3000, ok2);
    repeat (40) @(negedge clk);
    decode(q1, 0, 0, 32, bytes, pbits, starts, ferr, perr);
    checks++; if (!ok1 || bytes.size() !== 1 || bytes[0] !== 8'h80 || ferr !== 0) begin
      errors++; $display("FAIL cfg_noparity_byte got n=%0d ferr=%0d exp 80", bytes.size(), ferr);
    end
    last = (d1.size() > 0) ? d1[0] : 0;
    checks++; if (starts.size() !== 1 || last - starts[0] !== (1 + 8) * 16 + 32) begin
      errors++; $display("FAIL cfg_noparity_length got %0d exp %0d", (starts.size() > 0) ? last - starts[0] : -1, (1 + 8) * 16 + 32);
    end
    ones = 0;
    for (int k = last - 32; k < last; k++) if (k >= 0 && k < q1.size() && q1[k] === 1'b1) ones++;
    checks++; if (ones !== 32) begin errors++; $display("FAIL cfg_stop_high got %0d exp 32", ones); end
    decode(q2, 1, 1, 16, bytes, pbits, starts, ferr, perr);
    dbyte = 8'h07;
    exp_par = ~(^dbyte);
    checks++; if (!ok2 || bytes.size() !== 1 || bytes[0] !== 8'h07 || pbits.size() !== 1 || pbits[0] !== exp_par) begin
      errors++; $display("FAIL cfg_odd_parity got n=%0d exp byte 07 parity %b", bytes.size(), exp_par);
    end
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] bytes[$];
    logic pbits[$];
    int starts[$];
    int ferr, perr, base, bad;
    logic [7:0] r;
    bit ok;
    tick_div = $urandom_range(2, 6);
    clear_capture();
    tick_en = 1'b1;
    base = done_cnt0;
    sent = {};
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      sent.push_back(r);
      push(0, r);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_done(0, base + 5, 5 * 176 * 6 + 2000, ok);
    repeat (40) @(negedge clk);
    decode(q0, 1, 0, 16, bytes, pbits, starts, ferr, perr);
    bad = 0;
    foreach (sent[i]) if (i >= bytes.size() || bytes[i] !== sent[i]) bad++;
    checks++; if (!ok || bytes.size() !== 5 || bad !== 0) begin
      errors++; $display("FAIL random_bytes got n=%0d mismatched %0d exp 5 0 (div %0d)", bytes.size(), bad, tick_div);
    end
    checks++; if (perr !== 0 || ferr !== 0) begin errors++; $display("FAIL random_errors got parity %0d frame %0d exp 0 0", perr, ferr); end
    tick_div = 4;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_push_timing();
    test_reset_mid();
    test_single_byte();
    test_loopback();
    test_full();
    test_simultaneous();
    test_config();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
